// File: rtl/lfsr_pkg.sv
// Shared constants for the x^4+x+1 LFSR generator and its receive-side checker.
package lfsr_pkg;

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] HUNT   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int unsigned LFSR_W      = 4;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 4'b0010;
  localparam int unsigned TAP_A       = 0;
  localparam int unsigned TAP_B       = 1;
  localparam int unsigned LFSR_PERIOD = 15;

  // Next bit of the stream given the last LFSR_W bits, oldest at index 0.
  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] hist);
    return hist[TAP_A] ^ hist[TAP_B];
  endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module lfsr_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 4-bit LFSR stream: fill, hunt for lock, then flywheel
// on its own prediction while counting bit errors and dropping lock when they cluster.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_CNT    = 8,
  parameter int unsigned ERR_WIN     = 16,
  parameter int unsigned LOSS_THRESH = 3,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             din,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int unsigned WIN_W  = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
  localparam int unsigned WERR_W = $clog2(LOSS_THRESH + 1);

  localparam logic [3:0]        LOCK_V   = 4'(LOCK_CNT);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(ERR_WIN - 1);
  localparam logic [WERR_W-1:0] LOSS_V   = WERR_W'(LOSS_THRESH);

  logic [1:0]        state_q, state_d;
  logic [3:0]        hist_q, hist_d;
  logic [1:0]        fill_q, fill_d;
  logic [3:0]        match_q, match_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0] win_err_q, win_err_d, win_err_nxt;
  logic              locked_q, pulse_q, pulse_d;
  logic              pred, mismatch, err_inc;

  assign pred     = lfsr_feedback(hist_q);
  // An all-zero history can never be a valid LFSR state, so it never matches.
  assign mismatch = (din != pred) || (hist_q == 4'b0000);

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    win_err_nxt = win_err_q;
    pulse_d     = 1'b0;
    err_inc     = 1'b0;

    if (enable) begin
      case (state_q)
        FILL: begin
          hist_d = {din, hist_q[3:1]};
          if (fill_q == 2'd3) begin
            fill_d  = '0;
            state_d = HUNT;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end

        HUNT: begin
          hist_d = {din, hist_q[3:1]};
          if (mismatch) begin
            match_d = '0;
          end else if (match_q + 4'd1 == LOCK_V) begin
            match_d   = '0;
            win_cnt_d = '0;
            win_err_d = '0;
            state_d   = LOCKED;
          end else begin
            match_d = match_q + 1'b1;
          end
        end

        LOCKED: begin
          // Flywheel: feed back the prediction so a bad bit cannot corrupt the history.
          hist_d = {pred, hist_q[3:1]};
          if (mismatch) begin
            pulse_d     = 1'b1;
            err_inc     = 1'b1;
            win_err_nxt = win_err_q + 1'b1;
          end
          if (mismatch && (win_err_nxt >= LOSS_V)) begin
            state_d   = FILL;
            hist_d    = '0;
            fill_d    = '0;
            match_d   = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_nxt;
          end
        end

        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FILL;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      locked_q  <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      locked_q  <= (state_d == LOCKED);
      pulse_q   <= pulse_d;
    end
  end

  lfsr_sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_err),
    .inc  (err_inc),
    .count(err_count)
  );

  assign state     = state_q;
  assign locked    = locked_q;
  assign err_pulse = pulse_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised bench for lfsr_checker: a recurrence-based model of the checker runs beside two
// instances (16-bit and 2-bit error counters) and is compared every cycle.
module tb_lfsr_checker;
  import lfsr_pkg::*;

  localparam int LOCK = 8;
  localparam int WIN  = 16;
  localparam int LOSS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       din = 1'b0;
  logic       clr_err = 1'b0;
  logic       locked_a, pulse_a, locked_b, pulse_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b, state_a, state_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr_checker #(
    .LOCK_CNT(LOCK), .ERR_WIN(WIN), .LOSS_THRESH(LOSS), .ERR_W(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .din(din), .clr_err(clr_err),
    .locked(locked_a), .err_pulse(pulse_a), .err_count(cnt_a), .state(state_a)
  );

  lfsr_checker #(
    .LOCK_CNT(LOCK), .ERR_WIN(WIN), .LOSS_THRESH(LOSS), .ERR_W(2)
  ) dut_w2 (
    .clk(clk), .rst(rst), .enable(enable), .din(din), .clr_err(clr_err),
    .locked(locked_b), .err_pulse(pulse_b), .err_count(cnt_b), .state(state_b)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the stream rule b[n+4] = b[n] ^ b[n+1] over a queue of accepted bits.
  int m_state, m_fill, m_match, m_since, m_werr, m_ec_a, m_ec_b;
  bit m_pulse;
  bit m_hist[$];

  task automatic model_clear_hist();
    m_hist.delete();
    repeat (4) m_hist.push_back(1'b0);
  endtask

  task automatic model_shift(input bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endtask

  task automatic model_reset();
    m_state = 0; m_fill = 0; m_match = 0; m_since = 0; m_werr = 0;
    m_ec_a = 0; m_ec_b = 0; m_pulse = 0;
    model_clear_hist();
  endtask

  task automatic model_step(input bit d, input bit en, input bit clr);
    bit pred, good;
    m_pulse = 0;
    if (en) begin
      pred = m_hist[0] ^ m_hist[1];
      good = (d == pred) && (m_hist[0] | m_hist[1] | m_hist[2] | m_hist[3]);
      if (m_state == 0) begin
        model_shift(d);
        m_fill++;
        if (m_fill == 4) begin m_fill = 0; m_state = 1; end
      end else if (m_state == 1) begin
        model_shift(d);
        if (!good) m_match = 0;
        else begin
          m_match++;
          if (m_match == LOCK) begin m_state = 2; m_match = 0; m_since = 0; m_werr = 0; end
        end
      end else begin
        model_shift(pred);
        if (!good) begin
          m_pulse = 1;
          m_werr++;
          if (m_ec_a < 65535) m_ec_a++;
          if (m_ec_b < 3) m_ec_b++;
        end
        if (!good && m_werr >= LOSS) begin
          m_state = 0; m_fill = 0; m_match = 0; m_since = 0; m_werr = 0;
          model_clear_hist();
        end else begin
          m_since++;
          if (m_since % WIN == 0) m_werr = 0;
        end
      end
    end
    if (clr) begin m_ec_a = 0; m_ec_b = 0; end
  endtask

  initial model_reset();

  // Compare process: update the model with what the DUT sampled, then check after the edge.
  always @(posedge clk) begin
    if (!rst) model_reset();
    else model_step(din, enable, clr_err);
    #1;
    chk("state_a", int'(state_a), m_state);
    chk("locked_a", int'(locked_a), int'(m_state == 2));
    chk("pulse_a", int'(pulse_a), int'(m_pulse));
    chk("count_a", int'(cnt_a), m_ec_a);
    chk("state_b", int'(state_b), m_state);
    chk("locked_b", int'(locked_b), int'(m_state == 2));
    chk("pulse_b", int'(pulse_b), int'(m_pulse));
    chk("count_b", int'(cnt_b), m_ec_b);
  end

  // Stimulus
  bit seq[LFSR_PERIOD];
  int gp = 0;

  task automatic cyc(input bit d, input bit en, input bit c);
    @(negedge clk);
    din = d; enable = en; clr_err = c;
    @(posedge clk);
    #2;
  endtask

  task automatic send(input bit flip, input int gap_pct, input bit c);
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) cyc(1'($urandom_range(1)), 1'b0, 1'b0);
    cyc(seq[gp] ^ flip, 1'b1, c);
    gp = (gp + 1) % LFSR_PERIOD;
  endtask

  task automatic send_n(input int n, input int gap_pct);
    repeat (n) send(1'b0, gap_pct, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0; clr_err = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic relock_check(input string tag, input int gap_pct);
    for (int i = 1; i <= LOCK + 4; i++) begin
      send(1'b0, gap_pct, 1'b0);
      if (i == LOCK + 3) chk({tag, "_not_yet"}, int'(locked_a), 0);
      if (i == LOCK + 4) chk({tag, "_locked"}, int'(locked_a), 1);
    end
  endtask

  initial begin
    logic [LFSR_W-1:0] s;
    int packed_seq;
    s = LFSR_SEED;
    for (int i = 0; i < 4; i++) seq[i] = s[i];
    for (int i = 4; i < LFSR_PERIOD; i++) seq[i] = seq[i-4] ^ seq[i-3];
    packed_seq = 0;
    for (int i = 0; i < LFSR_PERIOD; i++) packed_seq += int'(seq[i]) << i;
    chk("stream_from_seed", packed_seq, 7858);

    #1;
    chk("rst_state", int'(state_a), 0);
    chk("rst_locked", int'(locked_a), 0);
    chk("rst_pulse", int'(pulse_a), 0);
    chk("rst_count", int'(cnt_a), 0);
    @(negedge clk);
    rst = 1'b1;

    // Clean stream from the seed phase.
    gp = 0;
    for (int i = 1; i <= 100; i++) begin
      send(1'b0, 0, 1'b0);
      if (i == 3) chk("fill_at_3", int'(state_a), int'(FILL));
      if (i == 4) chk("hunt_at_4", int'(state_a), int'(HUNT));
      if (i == 11) chk("unlocked_at_11", int'(locked_a), 0);
      if (i == 12) chk("locked_at_12", int'(locked_a), 1);
    end
    chk("clean_100_errs", int'(cnt_a), 0);

    // Single isolated error.
    send_n(19, 0);
    send(1'b1, 0, 1'b0);
    chk("single_pulse", int'(pulse_a), 1);
    chk("single_count", int'(cnt_a), 1);
    chk("single_locked", int'(locked_a), 1);
    send_n(40, 0);
    chk("single_after", int'(cnt_a), 1);
    chk("single_after_lock", int'(locked_a), 1);

    // Three errors in one window (lock-relative bits 148,150,152 fall in window 144..159).
    cyc(1'b0, 1'b0, 1'b1);
    chk("clr_idle", int'(cnt_a), 0);
    send(1'b1, 0, 1'b0);
    send(1'b0, 0, 1'b0);
    send(1'b1, 0, 1'b0);
    chk("burst_still_locked", int'(locked_a), 1);
    send(1'b0, 0, 1'b0);
    send(1'b1, 0, 1'b0);
    chk("burst_to_fill", int'(state_a), int'(FILL));
    chk("burst_count", int'(cnt_a), 3);
    relock_check("burst_relock", 0);
    chk("burst_count_kept", int'(cnt_a), 3);

    // Dead line.
    repeat (50) cyc(1'b0, 1'b1, 1'b0);
    chk("dead_unlocked", int'(locked_a), 0);
    chk("dead_hunting", int'(state_a), int'(HUNT));

    // Phase jump in the middle of HUNT.
    do_reset();
    gp = int'($urandom_range(LFSR_PERIOD - 1));
    send_n(8, 0);
    gp = (gp + 5) % LFSR_PERIOD;
    send_n(4, 0);
    chk("jump_unlocked", int'(locked_a), 0);
    send_n(20, 0);
    chk("jump_relocked", int'(locked_a), 1);

    // Random enable gaps, then random errors with gaps, then fully random input.
    do_reset();
    gp = int'($urandom_range(LFSR_PERIOD - 1));
    relock_check("gap_lock", 40);
    repeat (300) send(1'($urandom_range(99) < 4), 30, 1'b0);
    repeat (200) cyc(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(99) < 5));

    // Saturation of the 2-bit counter.
    do_reset();
    relock_check("sat_lock", 0);
    cyc(1'b0, 1'b0, 1'b1);
    repeat (5) begin
      send_n(19, 0);
      send(1'b1, 0, 1'b0);
    end
    chk("sat_w2", int'(cnt_b), 3);
    chk("sat_w16", int'(cnt_a), 5);
    chk("sat_locked", int'(locked_a), 1);

    // Clear in the same cycle as a counted error.
    send_n(19, 0);
    send(1'b1, 0, 1'b1);
    chk("clr_err_pulse", int'(pulse_a), 1);
    chk("clr_err_count", int'(cnt_a), 0);
    chk("clr_err_count_w2", int'(cnt_b), 0);

    // Asynchronous reset while locked.
    send_n(5, 0);
    chk("pre_rst_locked", int'(locked_a), 1);
    #1;
    rst = 1'b0;
    enable = 1'b0;
    #1;
    chk("async_state", int'(state_a), 0);
    chk("async_locked", int'(locked_a), 0);
    chk("async_pulse", int'(pulse_a), 0);
    chk("async_count", int'(cnt_a), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    relock_check("post_rst", 0);

    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial receive-side checker for the 4-bit LFSR generator (x⁴+x+1, period 15), which emits its state LSB once per enabled cycle. It self-synchronises to the incoming bit stream and declares lock after a run of correct predictions. Once locked, it flywheels on its own prediction, counts bit errors and drops lock when errors cluster. It sits at the far end of the link or loopback as the built-in self-test monitor.

## Interface
Parameters:
- LOCK_CNT, default 8: consecutive correct predictions in HUNT needed to lock (range 1..15).
- ERR_WIN, default 16: window length, in enabled bits, for loss-of-lock evaluation.
- LOSS_THRESH, default 3: errors within one window that force loss of lock.
- ERR_W, default 16: width of the saturating error counter.

Ports:
- clk: input, 1 bit. Single clock, rising edge.
- rst: input, 1 bit. Asynchronous, active-low reset.
- enable: input, 1 bit. `din` is valid this cycle; all state holds when low.
- din: input, 1 bit. Received serial bit.
- clr_err: input, 1 bit. Synchronous clear of `err_count`.
- locked: output, 1 bit. High while in the LOCKED state.
- err_pulse: output, 1 bit. One-cycle pulse per mismatched bit while LOCKED.
- err_count: output, ERR_W bits. Saturating mismatch count.
- state: output, 2 bits. FILL=0, HUNT=1, LOCKED=2.

## Operation
- The generator sequence obeys b[n+4] = b[n] ^ b[n+1]. From seed 0010 the stream is 0,1,0,0,1,1,0,1,0,1,1,1,1,0,0, repeating.
- History `hist[3:0]` holds the last 4 accepted bits; `hist[0]` is the oldest. On each accepted bit, `hist` shifts right with the new bit entering at `hist[3]`.
- Prediction: `pred = hist[0] ^ hist[1]`.
- A bit "matches" when `din == pred` and `hist != 4'b0000`. An all-zero history always counts as a mismatch, so a dead line never locks.
- FILL: shift in `din` and count 4 enabled bits, then go to HUNT. No comparisons are made in FILL.
- HUNT: always shift in `din`.
  - On a match, increment `match_cnt`.
  - On a mismatch, set `match_cnt` to 0.
  - When a match brings `match_cnt` to LOCK_CNT, go to LOCKED and clear the window and window-error counters.
- LOCKED (flywheel): shift in `pred`, not `din`, so an isolated error does not corrupt the history.
  - On a mismatch: pulse `err_pulse`, increment `err_count` (saturating at all-ones), and increment `win_err`.
  - If `win_err`, including the current bit, reaches LOSS_THRESH, go to FILL and clear `hist`, `match_cnt`, `win_cnt` and `win_err`.
  - `win_cnt` counts enabled bits from 0 to ERR_WIN-1. On wrap, `win_err` resets to 0 after the current bit's threshold check.
- `err_count` increments only in LOCKED. It is never cleared by loss of lock, only by `rst` or `clr_err`.
- If `clr_err` and a counted error occur in the same cycle, the clear wins and `err_count` becomes 0. `err_pulse` still fires.
- `enable` low: no state changes, and `err_pulse` is 0.

## Timing
- All outputs are registered. Reset values: `state`=FILL, `locked`=0, `err_pulse`=0, `err_count`=0; internal `hist`, counters = 0.
- Reset takes effect asynchronously at any time, including mid-LOCKED. Release is synchronous to the next rising edge.
- `err_pulse` is high for exactly the cycle after the edge that sampled the bad bit.
- `locked` and `state` change at the edge that samples the deciding bit.
- Latency with a clean stream and consecutive enables: `locked` rises after the (4 + LOCK_CNT)-th accepted bit, i.e. the 12th bit with defaults.
- Gaps in `enable` stretch the timing but never change the results.

## Structure
- Shared package `lfsr_pkg`:
  - state encoding constants FILL, HUNT, LOCKED;
  - LFSR width 4;
  - seed 4'b0010;
  - tap positions (0,1);
  - period 15.
  
  The generator and the checker both use this package.
- One sub-module, `lfsr_sat_counter`: a parameterised-width saturating counter with synchronous clear and increment, used for `err_count`.
- The FSM, history and window logic stay inline.

## Test plan
- Clean stream from seed 0010 with continuous `enable` → `state` goes FILL→HUNT after bit 4 and LOCKED after bit 12. `err_count` stays 0 for 100 bits.
- Locked, then flip the single bit 20 → one `err_pulse`, `err_count`=1, `locked` stays 1, and no further errors on bits 21–60.
- Locked, then flip 3 bits within one 16-bit window → `err_count`=3 and `state` returns to FILL on the third error. Relock occurs 12 clean bits later; `err_count` still 3.
- `din` held at 0 for 50 bits, and separately the stream phase-shifted mid-HUNT → never locks, or `match_cnt` restarts. Random `enable` gaps give results identical to the continuous case.
- Two cases:
  - ERR_W=2 with 5 isolated errors spaced 20 bits apart → `err_count` saturates at 3.
  - `clr_err` in the same cycle as an error → `err_count`=0, `err_pulse`=1.
- Assert `rst` low mid-LOCKED → outputs return to reset values immediately. After release, the block relocks 12 bits later.
